mem_access_sequencer: RTL and testbench
=======================================

// Module: mem_access_sequencer
// PURPOSE
//  Memory-stage sequencer between the multicycle control FSM and the 64-bit data memory.
//  Executes one load/store per start pulse: lb/lh/lw/ld/lbu/lhu/lwu and sb/sh/sw/sd.
//  Partial stores run as read-modify-write on the aligned doubleword; loads are
//  lane-selected and sign/zero-extended. The control FSM holds its Evl*/Ams* state until done.
// PARAMETERS
//  ADDR_W  64  byte-address width (address from AluOut)
//  DATA_W  64  memory word width; only 64 is supported (8 byte lanes)
// PORTS
//  clk         in   1       clock, rising edge
//  reset       in   1       asynchronous, active-high
//  start       in   1       one-cycle request pulse; sampled only in IDLE
//  is_store    in   1       1 = store, 0 = load
//  funct3      in   3       instruction funct3 (access size and signedness)
//  addr        in   ADDR_W  effective byte address
//  store_data  in   DATA_W  rs2 value (register B)
//  busy        out  1       high from the cycle after start is accepted until DONE
//  done        out  1       one-cycle completion pulse
//  err         out  1       valid with done: misaligned access or unsupported funct3
//  load_data   out  DATA_W  extended load result; updated only on a successful load
//  mem_addr    out  ADDR_W  {addr[ADDR_W-1:3],3'b000} of latched request
//  mem_wr      out  1       memory write strobe, one cycle per store
//  mem_wdata   out  DATA_W  doubleword to write
//  mem_rdata   in   DATA_W  memory read data, valid 1 cycle after mem_addr with mem_wr=0
// BEHAVIOUR
//  Reset (async): state=IDLE; busy, done, err, mem_wr = 0; load_data, mem_addr, mem_wdata,
//   and all latched request registers = 0. Reset mid-access aborts immediately: mem_wr drops
//   in the same cycle and no write completes.
//  States: IDLE, RD, WT, WR, DONE. In IDLE, start latches is_store/funct3/addr/store_data.
//  IDLE + start: bad request -> DONE (err=1, no memory access); sd -> WR; else -> RD.
//  Bad request: load funct3=111; store funct3[2]=1; misaligned: size 2 & addr[0]!=0,
//   size 4 & addr[1:0]!=0, size 8 & addr[2:0]!=0. Size is 1/2/4/8 from funct3[1:0].
//  RD: present mem_addr, mem_wr=0 -> WT.
//  WT: capture mem_rdata. Load: lane k=addr[2:0], extract size bytes from bit 8k,
//   sign-extend if funct3[2]=0, else zero-extend; register into load_data -> DONE.
//   Partial store: merge store_data low bytes into lanes k..k+size-1 -> WR.
//  WR: mem_wr=1 for exactly one cycle; mem_wdata = merged word (sd: store_data) -> DONE.
//  DONE: done=1 and err valid for one cycle -> IDLE. err clears on the next start.
//  Latency from start cycle T: done at T+3 for loads, T+4 for sb/sh/sw,
//   T+2 for sd, and T+1 for bad requests.
//  start while busy or in DONE is ignored (no queuing). Inputs are not re-sampled after IDLE.
//  Little-endian lanes: byte k = word[8k+7:8k]. Unwritten lanes keep their read value.
// TESTING
//  mem[0x10]=0x8877_6655_4433_2211, lb addr=0x17 -> done T+3, load_data=0xFFFF_FFFF_FFFF_FF88
//  Same word, lhu addr=0x16 -> load_data=0x0000_0000_0000_8877; lwu 0x14 -> 0x8877_6655
//  sh addr=0x12 data=0xABCD -> one mem_wr at T+3, wdata=0x8877_6655_ABCD_2211, done T+4
//  sd addr=0x18 data=0x0123_4567_89AB_CDEF -> no read cycle, mem_wr at T+1, done T+2
//  lw addr=0x0E -> done T+1 with err=1, mem_wr never high, load_data unchanged
//  sb started, reset asserted in WR -> mem_wr low that cycle, memory unchanged, idle after release

Source files
------------

// File: rtl/mem_access_sequencer.sv
// rtl/mem_access_sequencer.sv - memory-stage load/store sequencer for the 64-bit data memory
//
// Runs one load or store for each accepted start pulse. Loads read the aligned
// doubleword, then select and extend one lane. Partial stores run as a
// read-modify-write of the aligned doubleword. sd skips the read. A request
// that is misaligned or has an unsupported funct3 completes at once with err
// and makes no memory access.
//
// Ports
//   clk, reset            rising-edge clock; asynchronous active-high reset
//   start                 request pulse, sampled only while idle
//   is_store, funct3      access kind, size and signedness
//   addr, store_data      effective byte address and store operand (rs2)
//   busy                  request in flight (from the cycle after accept through done)
//   done, err             one-cycle completion pulse; err is meaningful with done
//   load_data             extended load result, changed only by a successful load
//   mem_addr              aligned doubleword address of the latched request
//   mem_wr, mem_wdata     one-cycle write strobe and the doubleword to write
//   mem_rdata             read data, valid one cycle after mem_addr is presented

module mem_access_sequencer #(
   parameter int ADDR_W = 64,
   parameter int DATA_W = 64   // only 64 (eight byte lanes) is supported
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic              is_store,
   input  logic [2:0]        funct3,
   input  logic [ADDR_W-1:0] addr,
   input  logic [DATA_W-1:0] store_data,
   output logic              busy,
   output logic              done,
   output logic              err,
   output logic [DATA_W-1:0] load_data,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_wr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata
);

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_RD   = 3'd1,
      S_WT   = 3'd2,
      S_WR   = 3'd3,
      S_DONE = 3'd4
   } state_t;

   state_t            state_q, state_d;
   logic              is_store_q, is_store_d;
   logic [2:0]        funct3_q, funct3_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] store_data_q, store_data_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;
   logic              err_q, err_d;
   logic              mem_wr_q, mem_wr_d;
   logic [DATA_W-1:0] load_data_q, load_data_d;
   logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;

   // Request check on the live inputs, used only in the cycle start is accepted.
   // Size in bytes is 1 << funct3[1:0]; an access is aligned when the address
   // bits below the size are zero.
   function automatic logic bad_request(input logic st, input logic [2:0] f3,
                                        input logic [2:0] lane);
      logic bad;
      bad = st ? f3[2] : (f3 == 3'b111);
      case (f3[1:0])
         2'd0:    bad = bad;
         2'd1:    bad = bad | lane[0];
         2'd2:    bad = bad | (lane[1:0] != 2'b00);
         default: bad = bad | (lane != 3'b000);
      endcase
      return bad;
   endfunction

   // Load lane select: shift the addressed lane down to bit 0, then keep the
   // access size and fill the upper bits with the sign bit (funct3[2]=0) or zero.
   function automatic logic [63:0] load_extract(input logic [63:0] word,
                                                input logic [2:0]  lane,
                                                input logic [2:0]  f3);
      logic [63:0] s;
      logic        sgn;
      logic [63:0] r;
      s   = word >> {lane, 3'b000};
      sgn = ~f3[2];
      case (f3[1:0])
         2'd0:    r = {{56{sgn & s[7]}},  s[7:0]};
         2'd1:    r = {{48{sgn & s[15]}}, s[15:0]};
         2'd2:    r = {{32{sgn & s[31]}}, s[31:0]};
         default: r = s;
      endcase
      return r;
   endfunction

   // Store merge: the low size bytes of the operand replace lanes
   // lane..lane+size-1; every other lane keeps what memory returned.
   function automatic logic [63:0] store_merge(input logic [63:0] word,
                                               input logic [63:0] data,
                                               input logic [2:0]  lane,
                                               input logic [2:0]  f3);
      logic [63:0] mask;
      case (f3[1:0])
         2'd0:    mask = 64'h0000_0000_0000_00FF;
         2'd1:    mask = 64'h0000_0000_0000_FFFF;
         2'd2:    mask = 64'h0000_0000_FFFF_FFFF;
         default: mask = 64'hFFFF_FFFF_FFFF_FFFF;
      endcase
      mask = mask << {lane, 3'b000};
      return (word & ~mask) | ((data << {lane, 3'b000}) & mask);
   endfunction

   always_comb begin
      state_d      = state_q;
      is_store_d   = is_store_q;
      funct3_d     = funct3_q;
      addr_d       = addr_q;
      store_data_d = store_data_q;
      err_d        = err_q;
      load_data_d  = load_data_q;
      mem_wdata_d  = mem_wdata_q;
      done_d       = 1'b0;
      mem_wr_d     = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (start) begin
               is_store_d   = is_store;
               funct3_d     = funct3;
               addr_d       = addr;
               store_data_d = store_data;
               err_d        = bad_request(is_store, funct3, addr[2:0]);
               if (bad_request(is_store, funct3, addr[2:0])) begin
                  state_d = S_DONE;
                  done_d  = 1'b1;
               end else if (is_store && (funct3[1:0] == 2'd3)) begin
                  // Full doubleword store: nothing to merge, write straight away.
                  state_d     = S_WR;
                  mem_wr_d    = 1'b1;
                  mem_wdata_d = store_data;
               end else begin
                  state_d = S_RD;
               end
            end
         end

         S_RD: begin
            // mem_addr already holds the aligned address; memory answers next cycle.
            state_d = S_WT;
         end

         S_WT: begin
            if (is_store_q) begin
               mem_wdata_d = store_merge(mem_rdata, store_data_q, addr_q[2:0], funct3_q);
               state_d     = S_WR;
               mem_wr_d    = 1'b1;
            end else begin
               load_data_d = load_extract(mem_rdata, addr_q[2:0], funct3_q);
               state_d     = S_DONE;
               done_d      = 1'b1;
            end
         end

         S_WR: begin
            state_d = S_DONE;
            done_d  = 1'b1;
         end

         S_DONE: begin
            // start is ignored here; the request is only taken again from idle.
            state_d = S_IDLE;
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase

      // Outputs are registered from the next state so each strobe lines up
      // with the cycle the FSM spends in the matching state.
      busy_d = (state_d != S_IDLE);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= S_IDLE;
         is_store_q   <= 1'b0;
         funct3_q     <= 3'd0;
         addr_q       <= '0;
         store_data_q <= '0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
         err_q        <= 1'b0;
         mem_wr_q     <= 1'b0;
         load_data_q  <= '0;
         mem_wdata_q  <= '0;
      end else begin
         state_q      <= state_d;
         is_store_q   <= is_store_d;
         funct3_q     <= funct3_d;
         addr_q       <= addr_d;
         store_data_q <= store_data_d;
         busy_q       <= busy_d;
         done_q       <= done_d;
         err_q        <= err_d;
         mem_wr_q     <= mem_wr_d;
         load_data_q  <= load_data_d;
         mem_wdata_q  <= mem_wdata_d;
      end
   end

   assign busy      = busy_q;
   assign done      = done_q;
   assign err       = err_q;
   assign load_data = load_data_q;
   assign mem_wr    = mem_wr_q;
   assign mem_wdata = mem_wdata_q;
   assign mem_addr  = {addr_q[ADDR_W-1:3], 3'b000};

endmodule

// File: tb/tb_mem_access_sequencer.sv
// tb/tb_mem_access_sequencer.sv - self-checking bench for mem_access_sequencer
//
// Drives directed and random load/store requests into the sequencer, which is
// attached to a 32-doubleword memory model. Expected timing, strobes, load
// results and memory contents come from a byte-level reference model.

module tb_mem_access_sequencer;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic        is_store;
   logic [2:0]  funct3;
   logic [63:0] addr;
   logic [63:0] store_data;
   logic        busy;
   logic        done;
   logic        err;
   logic [63:0] load_data;
   logic [63:0] mem_addr;
   logic        mem_wr;
   logic [63:0] mem_wdata;
   logic [63:0] mem_rdata;

   logic [63:0] mem     [0:31];
   logic [63:0] ref_mem [0:31];
   logic        init_mem;

   int checks   = 0;
   int failures = 0;

   logic        check_en  = 1'b0;
   logic        exp_busy  = 1'b0;
   logic        exp_done  = 1'b0;
   logic        exp_wr    = 1'b0;
   logic        exp_err   = 1'b0;
   logic [63:0] exp_load  = 64'd0;
   logic [63:0] exp_addr  = 64'd0;
   logic [63:0] exp_wdata = 64'd0;

   mem_access_sequencer #(.ADDR_W(64), .DATA_W(64)) dut (
      .clk        (clk),
      .reset      (reset),
      .start      (start),
      .is_store   (is_store),
      .funct3     (funct3),
      .addr       (addr),
      .store_data (store_data),
      .busy       (busy),
      .done       (done),
      .err        (err),
      .load_data  (load_data),
      .mem_addr   (mem_addr),
      .mem_wr     (mem_wr),
      .mem_wdata  (mem_wdata),
      .mem_rdata  (mem_rdata)
   );

   always #5 clk = ~clk;

   // Synchronous-read memory: data for mem_addr appears one cycle later.
   always @(posedge clk) begin
      mem_rdata <= mem[mem_addr[7:3]];
      if (init_mem) begin
         for (int i = 0; i < 32; i++) mem[i] <= ref_mem[i];
      end else if (mem_wr) begin
         mem[mem_addr[7:3]] <= mem_wdata;
      end
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   // Per-cycle compare against the expectations the driver publishes.
   always @(negedge clk) begin
      if (check_en) begin
         chk("busy", 64'(busy), 64'(exp_busy));
         chk("done", 64'(done), 64'(exp_done));
         chk("mem_wr", 64'(mem_wr), 64'(exp_wr));
         chk("load_data", load_data, exp_load);
         if (exp_busy) chk("mem_addr", mem_addr, exp_addr);
         if (exp_wr)   chk("mem_wdata", mem_wdata, exp_wdata);
         if (exp_done) chk("err", 64'(err), 64'(exp_err));
      end
   end

   // Issues one request and steps the expectations through its lifetime.
   // meas returns the cycle offset where the DUT raised done (-1 if never).
   task automatic run_op(input logic st, input logic [2:0] f3, input logic [63:0] a,
                         input logic [63:0] d, output int meas);
      int          size;
      int          k;
      int          lat;
      logic        bad;
      logic [4:0]  idx;
      logic [63:0] old_w;
      logic [63:0] new_w;
      logic [63:0] ld;

      size  = 1 << f3[1:0];
      k     = int'(a[2:0]);
      idx   = a[7:3];
      bad   = st ? f3[2] : (f3 == 3'b111);
      if ((k % size) != 0) bad = 1'b1;
      old_w = ref_mem[idx];
      new_w = old_w;
      ld    = 64'd0;
      if (!bad) begin
         for (int i = 0; i < size; i++) begin
            new_w[8*(k+i) +: 8] = d[8*i +: 8];
            ld[8*i +: 8]        = old_w[8*(k+i) +: 8];
         end
         if (!f3[2] && size < 8 && ld[8*size-1]) begin
            for (int i = size; i < 8; i++) ld[8*i +: 8] = 8'hFF;
         end
      end
      if (bad)            lat = 1;
      else if (!st)       lat = 3;
      else if (size == 8) lat = 2;
      else                lat = 4;
      meas = -1;

      @(posedge clk); #1;
      start      = 1'b1;
      is_store   = st;
      funct3     = f3;
      addr       = a;
      store_data = d;
      exp_busy   = 1'b0;
      exp_done   = 1'b0;
      exp_wr     = 1'b0;
      check_en   = 1'b1;

      for (int n = 1; n <= lat; n++) begin
         @(posedge clk); #1;
         if (done && meas < 0) meas = n;
         // Noise on the request inputs must not disturb an access in flight.
         start      = 1'($urandom_range(0, 1));
         is_store   = 1'($urandom_range(0, 1));
         funct3     = 3'($urandom);
         addr       = {$urandom, $urandom};
         store_data = {$urandom, $urandom};
         exp_busy   = 1'b1;
         exp_done   = (n == lat);
         exp_wr     = st && !bad && (n == lat - 1);
         exp_addr   = {a[63:3], 3'b000};
         exp_wdata  = new_w;
         exp_err    = bad;
         if (!st && !bad && n == lat) exp_load = ld;
      end

      @(posedge clk); #1;
      start    = 1'b0;
      exp_busy = 1'b0;
      exp_done = 1'b0;
      exp_wr   = 1'b0;
      if (st && !bad) ref_mem[idx] = new_w;
      chk("mem_word", mem[idx], ref_mem[idx]);
      chk("latency", 64'(meas), 64'(lat));
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog time limit reached checks=%0d", checks);
      $fatal(1, "watchdog");
   end

   initial begin
      int          meas;
      logic        st;
      logic [2:0]  f3;
      logic [63:0] a;
      logic [63:0] d;
      int          size;

      reset      = 1'b1;
      init_mem   = 1'b1;
      start      = 1'b0;
      is_store   = 1'b0;
      funct3     = 3'd0;
      addr       = 64'd0;
      store_data = 64'd0;
      for (int i = 0; i < 32; i++) ref_mem[i] = {$urandom, $urandom};
      ref_mem[2] = 64'h8877_6655_4433_2211;

      repeat (3) @(posedge clk);
      #1;
      chk("reset_busy", 64'(busy), 64'd0);
      chk("reset_done", 64'(done), 64'd0);
      chk("reset_err", 64'(err), 64'd0);
      chk("reset_mem_wr", 64'(mem_wr), 64'd0);
      chk("reset_load_data", load_data, 64'd0);
      chk("reset_mem_addr", mem_addr, 64'd0);
      chk("reset_mem_wdata", mem_wdata, 64'd0);
      reset    = 1'b0;
      init_mem = 1'b0;

      // Directed cases with hand-computed results.
      run_op(1'b0, 3'b000, 64'h17, 64'd0, meas);
      chk("lit_lb_data", load_data, 64'hFFFF_FFFF_FFFF_FF88);
      chk("lit_lb_latency", 64'(meas), 64'd3);
      run_op(1'b0, 3'b101, 64'h16, 64'd0, meas);
      chk("lit_lhu_data", load_data, 64'h0000_0000_0000_8877);
      run_op(1'b0, 3'b110, 64'h14, 64'd0, meas);
      chk("lit_lwu_data", load_data, 64'h0000_0000_8877_6655);
      run_op(1'b1, 3'b001, 64'h12, 64'h0000_0000_0000_ABCD, meas);
      chk("lit_sh_word", mem[2], 64'h8877_6655_ABCD_2211);
      chk("lit_sh_latency", 64'(meas), 64'd4);
      run_op(1'b1, 3'b011, 64'h18, 64'h0123_4567_89AB_CDEF, meas);
      chk("lit_sd_word", mem[3], 64'h0123_4567_89AB_CDEF);
      chk("lit_sd_latency", 64'(meas), 64'd2);
      run_op(1'b0, 3'b010, 64'h0E, 64'd0, meas);
      chk("lit_lw_misaligned_latency", 64'(meas), 64'd1);
      chk("lit_lw_misaligned_err", 64'(err), 64'd1);
      chk("lit_lw_misaligned_keep", load_data, 64'h0000_0000_8877_6655);
      run_op(1'b0, 3'b111, 64'h10, 64'd0, meas);
      run_op(1'b1, 3'b100, 64'h10, 64'h55, meas);
      run_op(1'b0, 3'b011, 64'h10, 64'd0, meas);
      chk("lit_ld_data", load_data, 64'h8877_6655_ABCD_2211);
      chk("lit_err_cleared", 64'(err), 64'd0);

      // Reset during the write cycle of an sb: the strobe drops at once.
      check_en = 1'b0;
      @(posedge clk); #1;
      start      = 1'b1;
      is_store   = 1'b1;
      funct3     = 3'b000;
      addr       = 64'h21;
      store_data = 64'h5A;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_wr_before", 64'(mem_wr), 64'd1);
      #2;
      reset = 1'b1;
      #1;
      chk("rst_wr_dropped", 64'(mem_wr), 64'd0);
      chk("rst_busy_dropped", 64'(busy), 64'd0);
      @(posedge clk); #1;
      @(posedge clk); #1;
      reset    = 1'b0;
      exp_load = 64'd0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_idle_busy", 64'(busy), 64'd0);
      chk("rst_idle_done", 64'(done), 64'd0);
      chk("rst_load_data", load_data, 64'd0);
      chk("rst_mem_unchanged", mem[4], ref_mem[4]);

      // Random traffic, biased toward aligned addresses.
      for (int t = 0; t < 200; t++) begin
         st   = 1'($urandom_range(0, 1));
         f3   = 3'($urandom);
         size = 1 << f3[1:0];
         a    = {$urandom, $urandom};
         if ($urandom_range(0, 3) != 0) a[2:0] = a[2:0] & ~3'(size - 1);
         d    = {$urandom, $urandom};
         run_op(st, f3, a, d, meas);
      end

      check_en = 1'b0;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
